// File: rtl/aes_pkg.sv
// AES-256 constants, word/round-key types and small helpers shared by the
// reverse key-schedule block.
package aes_pkg;

  localparam int NK     = 8;
  localparam int NR     = 14;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [4*WORD_W-1:0] rkey_t;
  typedef logic [3:0]          round_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OUT_HI,
    ST_OUT_LO,
    ST_GEN,
    ST_OUT,
    ST_DONE
  } state_t;

  // Round constant for word index i, addressed by i/8 (1..7 -> 01..40).
  function automatic logic [7:0] rcon(input logic [2:0] n);
    rcon = 8'h01 << (n - 3'd1);
  endfunction

  function automatic word_t rot_word(input word_t x);
    rot_word = {x[23:0], x[31:24]};
  endfunction

endpackage

// File: rtl/aes256_inv_key_expand_if.sv
// Load/round-key stream bundle between the key-schedule block and its user.
interface aes256_inv_key_expand_if;
  import aes_pkg::*;

  logic         start;
  logic [255:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  rkey_t        rk_data;
  round_t       rk_round;
  logic         done;

  modport master (
    output start, key_in, rk_ready,
    input  busy, rk_valid, rk_data, rk_round, done
  );

  modport slave (
    input  start, key_in, rk_ready,
    output busy, rk_valid, rk_data, rk_round, done
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES S-box: GF(2^8) multiplicative inverse (x^254 addition
// chain over the AES polynomial 0x11b) followed by the affine transform.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] prod;
    sq   = gf_mul(x, x);
    prod = sq;
    for (int k = 0; k < 6; k++) begin
      sq   = gf_mul(sq, sq);
      prod = gf_mul(prod, sq);
    end
    return prod;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] a);
    affine = a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
               ^ {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  assign out_byte = affine(gf_inv(in_byte));

endmodule

// File: rtl/aes256_inv_key_expand.sv
// Reverse AES-256 key schedule: from w52..w59 regenerates round keys 14..0,
// one word per cycle, emitting each round key as a 128-bit stream beat.
module aes256_inv_key_expand
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  aes256_inv_key_expand_if.slave kx
);

  state_t     state;
  word_t      win [NK];
  logic [5:0] idx;
  round_t     round_cnt;
  logic [1:0] step;

  word_t sub_in;
  word_t sub_out;
  word_t t_word;
  word_t new_word;
  logic  hs;

  assign hs = kx.rk_valid & kx.rk_ready;

  // One SubWord serves both the i%8==0 (rotated) and i%8==4 branches.
  assign sub_in = (idx[2:0] == 3'd0) ? rot_word(win[6]) : win[6];

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (sub_in[8*g +: 8]),
      .out_byte (sub_out[8*g +: 8])
    );
  end

  always_comb begin
    t_word = win[6];
    if (idx[2:0] == 3'd0) begin
      t_word = sub_out ^ {rcon(idx[5:3]), 24'h000000};
    end else if (idx[2:0] == 3'd4) begin
      t_word = sub_out;
    end
  end

  assign new_word = win[7] ^ t_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      for (int k = 0; k < NK; k++) win[k] <= '0;
      idx         <= '0;
      round_cnt   <= '0;
      step        <= '0;
      kx.busy     <= 1'b0;
      kx.rk_valid <= 1'b0;
      kx.rk_data  <= '0;
      kx.rk_round <= '0;
      kx.done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (kx.start) begin
            for (int k = 0; k < NK; k++) win[k] <= kx.key_in[255-32*k -: 32];
            idx         <= 6'd59;
            round_cnt   <= round_t'(NR);
            kx.busy     <= 1'b1;
            kx.rk_valid <= 1'b1;
            kx.rk_data  <= kx.key_in[127:0];
            kx.rk_round <= round_t'(NR);
            state       <= ST_OUT_HI;
          end
        end

        ST_OUT_HI: begin
          if (hs) begin
            kx.rk_data  <= {win[0], win[1], win[2], win[3]};
            kx.rk_round <= round_t'(NR - 1);
            round_cnt   <= round_t'(NR - 1);
            state       <= ST_OUT_LO;
          end
        end

        ST_OUT_LO: begin
          if (hs) begin
            kx.rk_valid <= 1'b0;
            round_cnt   <= round_t'(NR - 2);
            step        <= 2'd0;
            state       <= ST_GEN;
          end
        end

        // Window slides down by one word per cycle; after four steps
        // win[0..3] holds w[4r..4r+3] for the current round.
        ST_GEN: begin
          win[0] <= new_word;
          for (int k = 1; k < NK; k++) win[k] <= win[k-1];
          idx  <= idx - 6'd1;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            kx.rk_valid <= 1'b1;
            kx.rk_data  <= {new_word, win[0], win[1], win[2]};
            kx.rk_round <= round_cnt;
            state       <= ST_OUT;
          end
        end

        ST_OUT: begin
          if (hs) begin
            kx.rk_valid <= 1'b0;
            if (round_cnt == '0) begin
              kx.busy <= 1'b0;
              kx.done <= 1'b1;
              state   <= ST_DONE;
            end else begin
              round_cnt <= round_cnt - round_t'(1);
              step      <= 2'd0;
              state     <= ST_GEN;
            end
          end
        end

        ST_DONE: begin
          kx.done <= 1'b0;
          state   <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
